// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the data-memory store bus.
// Word stores to BASE_ADDR queue a byte; BASE_ADDR+4 reads status and clears overflow on write.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [29:0] DATA_WORD = BASE_ADDR[31:2];
    localparam logic [29:0] STAT_WORD = BASE_ADDR[31:2] + 30'd1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    // FIFO state
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // Serialiser state
    logic [1:0]       state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic hit_data, hit_stat, addr_stat;
    logic fifo_full, fifo_empty;
    logic push, pop, bit_done, busy;
    logic [7:0] head;
    logic [31:0] status;

    logic unused_bits;
    assign unused_bits = ^{a[1:0], wd[31:8]};

    assign addr_stat  = (a[31:2] == STAT_WORD);
    assign hit_data   = we & (a[31:2] == DATA_WORD);
    assign hit_stat   = we & addr_stat;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = hit_data & ~fifo_full;
    assign head       = mem_q[rd_ptr_q];
    assign bit_done   = (bit_cnt_q == BIT_W'(CLKS_PER_BIT - 1));
    assign busy       = (state_q != StIdle);

    assign status = {28'd0, ovf_q, busy, fifo_empty, fifo_full};
    assign rd     = addr_stat ? status : 32'd0;
    assign tx     = tx_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = head;
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = StData;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            default: begin
                // End of stop bit chains straight into the next start bit when data waits.
                if (bit_done) begin
                    bit_cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A dropped byte outranks a same-cycle clear.
        ovf_d = ovf_q;
        if (hit_data && fifo_full) begin
            ovf_d = 1'b1;
        end else if (hit_stat) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wd[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores queue expected bytes, a line monitor decodes tx frames.
module tb_mmio_uart_tx;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] STAT = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        tx;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .DEPTH       (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .a    (a),
        .wd   (wd),
        .rd   (rd),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    logic [7:0] exp_q[$];
    int         frame_starts[$];
    bit         mon_active = 1'b0;
    int         mon_cyc    = 0;
    logic [7:0] mon_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line monitor: samples mid-bit, pops the scoreboard at the stop bit.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mon_active = 1'b0;
            exp_q.delete();
        end else begin
            if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cyc    = 0;
                    frame_starts.push_back(cyc);
                end
            end else begin
                mon_cyc++;
            end
            if (mon_active) begin
                if (mon_cyc == CPB / 2) begin
                    check("start_bit", {31'd0, tx}, 32'd0);
                end else if (mon_cyc % CPB == CPB / 2 && mon_cyc / CPB >= 1 && mon_cyc / CPB <= 8) begin
                    mon_byte[mon_cyc / CPB - 1] = tx;
                end else if (mon_cyc == 9 * CPB + CPB / 2) begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %0h expected none", mon_byte);
                    end else begin
                        check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                    end
                end
                if (mon_cyc == 10 * CPB - 1) mon_active = 1'b0;
            end
        end
    end

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input bit accept);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        wd = data;
        if (accept) exp_q.push_back(data[7:0]);
        @(negedge clk);
        we = 1'b0;
        a  = STAT;
    endtask

    task automatic expect_stat(input string name, input logic [31:0] exp);
        a = STAT;
        #1;
        check(name, rd, exp);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && rd[2] == 1'b0 && !mon_active) break;
        end
        check(name, {31'd0, i < max_cyc}, 32'd1);
    endtask

    task automatic check_back_to_back(input string name, input int n);
        check({name, "_count"}, frame_starts.size(), n);
        for (int i = 1; i < frame_starts.size(); i++) begin
            check({name, "_gap"}, frame_starts[i] - frame_starts[i-1], 10 * CPB);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        int high_n;
        reset = 1'b0;
        we    = 1'b0;
        a     = STAT;
        wd    = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state
        expect_stat("reset_status", 32'h2);
        check("reset_tx", {31'd0, tx}, 32'd1);
        a = 32'h108;
        #1 check("rd_other_addr", rd, 32'd0);
        a = BASE;
        #1 check("rd_data_addr", rd, 32'd0);

        // Single byte, busy for exactly one frame
        store(BASE, 32'hA5, 1'b1);
        expect_stat("after_push_status", 32'h0);
        busy_n = 0;
        repeat (60) begin
            @(negedge clk);
            #1;
            if (rd[2]) busy_n++;
        end
        check("busy_cycles", busy_n, 10 * CPB);
        expect_stat("single_done_status", 32'h2);

        // Burst of six: one pops immediately, 0x66 overflows
        frame_starts.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            we = 1'b1;
            a  = BASE;
            wd = 32'h11 * (i + 1);
            if (i < 5) exp_q.push_back(8'(32'h11 * (i + 1)));
        end
        @(negedge clk);
        we = 1'b0;
        expect_stat("burst_status", 32'hD);
        store(STAT, 32'hFFFF_FFFF, 1'b0);
        expect_stat("ovf_clear_status", 32'h5);
        wait_idle("burst_drain", 400);
        check_back_to_back("burst", 5);
        expect_stat("burst_done_status", 32'h2);

        // Store to an unmapped word does nothing
        store(32'h108, 32'h77, 1'b0);
        expect_stat("unmapped_store_status", 32'h2);

        // Push on the same edge that ends STOP and pops
        frame_starts.delete();
        store(BASE, 32'h5A, 1'b1);
        store(BASE, 32'h96, 1'b1);
        repeat (37) @(negedge clk);
        store(BASE, 32'hE7, 1'b1);
        expect_stat("collision_status", 32'h4);
        wait_idle("collision_drain", 200);
        check_back_to_back("collision", 3);

        // Mid-frame reset during data bit 3 discards everything queued
        frame_starts.delete();
        store(BASE, 32'h3C, 1'b1);
        store(BASE, 32'hC3, 1'b1);
        repeat (16) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_status", rd, 32'h2);
        high_n = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx === 1'b1) high_n++;
        end
        check("post_reset_tx_idle", high_n, 100);
        check("post_reset_frames", frame_starts.size(), 1);
        expect_stat("post_reset_status", 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
